// File: rtl/gate_check_pkg.sv
// Shared definitions for the gate truth-table checker.
//   state_e      : checker FSM state encoding (idle, drive vector, check response, done)
//   MAX_N_IN     : largest supported DUT input count
//   timer_width  : bit width needed to hold a settle count of SETTLE-1 (at least 1 bit)
package gate_check_pkg;

   typedef enum logic [1:0] {
      StIdle,
      StDrive,
      StCheck,
      StDone
   } state_e;

   localparam int unsigned MAX_N_IN = 8;

   function automatic int unsigned timer_width(input int unsigned settle);
      return (settle > 1) ? $clog2(settle) : 1;
   endfunction

endpackage

// File: rtl/settle_timer.sv
// Loadable down-counter that times how long a vector is held before sampling.
//   clk     in  : clock, rising edge
//   rst_n   in  : asynchronous active-low reset
//   load    in  : reload counter with SETTLE-1
//   en      in  : count down while nonzero
//   expired out : counter has reached zero
module settle_timer
   import gate_check_pkg::*;
#(
   parameter int unsigned SETTLE = 1
) (
   input  logic clk,
   input  logic rst_n,
   input  logic load,
   input  logic en,
   output logic expired
);

   localparam int unsigned W = timer_width(SETTLE);
   localparam logic [W-1:0] LoadVal = W'(SETTLE - 1);

   logic [W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load) begin
         cnt_d = LoadVal;
      end else if (en && (cnt_q != '0)) begin
         cnt_d = cnt_q - W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign expired = (cnt_q == '0);

endmodule

// File: rtl/gate_vector_checker.sv
// Exhaustive truth-table checker for one combinational gate. Applies every input vector,
// holds it SETTLE cycles, then compares the DUT response against the golden table TRUTH.
//   clk            in  : clock, rising edge
//   rst_n          in  : asynchronous active-low reset
//   start          in  : one-cycle request to run a full sweep (ignored while busy)
//   dut_in         out : registered vector driven to the DUT
//   dut_out        in  : DUT response
//   busy           out : sweep in progress
//   done           out : sweep complete, held until next start or reset
//   pass           out : done with zero mismatches
//   err_count      out : number of mismatching vectors
//   first_fail_vec out : lowest failing vector
//   first_fail_vld out : at least one mismatch this sweep
module gate_vector_checker
   import gate_check_pkg::*;
#(
   parameter int unsigned         N_IN   = 2,
   parameter logic [2**N_IN-1:0]  TRUTH  = 4'b1000,
   parameter int unsigned         SETTLE = 1
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            start,
   output logic [N_IN-1:0] dut_in,
   input  logic            dut_out,
   output logic            busy,
   output logic            done,
   output logic            pass,
   output logic [N_IN:0]   err_count,
   output logic [N_IN-1:0] first_fail_vec,
   output logic            first_fail_vld
);

   localparam logic [N_IN:0] LastVec = (N_IN + 1)'(2**N_IN - 1);

   state_e          state_q, state_d;
   logic            start_q;
   logic [N_IN:0]   vec_q, vec_d;
   logic [N_IN:0]   err_q, err_d;
   logic [N_IN-1:0] ff_vec_q, ff_vec_d;
   logic            ff_vld_q, ff_vld_d;
   logic            busy_q, busy_d;
   logic            done_q, done_d;
   logic            pass_q, pass_d;
   logic            timer_load;
   logic            timer_expired;
   logic            mismatch;

   settle_timer #(
      .SETTLE (SETTLE)
   ) u_settle_timer (
      .clk     (clk),
      .rst_n   (rst_n),
      .load    (timer_load),
      .en      (state_q == StDrive),
      .expired (timer_expired)
   );

   // Written so an X/Z response falls through to the mismatch branch.
   always_comb begin
      mismatch = 1'b1;
      if (dut_out == TRUTH[vec_q[N_IN-1:0]]) begin
         mismatch = 1'b0;
      end
   end

   always_comb begin
      state_d    = state_q;
      vec_d      = vec_q;
      err_d      = err_q;
      ff_vec_d   = ff_vec_q;
      ff_vld_d   = ff_vld_q;
      busy_d     = busy_q;
      done_d     = done_q;
      pass_d     = pass_q;
      timer_load = 1'b0;

      unique case (state_q)
         StIdle, StDone: begin
            if (start_q) begin
               state_d    = StDrive;
               vec_d      = '0;
               err_d      = '0;
               ff_vec_d   = '0;
               ff_vld_d   = 1'b0;
               busy_d     = 1'b1;
               done_d     = 1'b0;
               pass_d     = 1'b0;
               timer_load = 1'b1;
            end
         end
         StDrive: begin
            if (timer_expired) begin
               state_d = StCheck;
            end
         end
         StCheck: begin
            if (mismatch) begin
               err_d = err_q + (N_IN + 1)'(1);
               if (!ff_vld_q) begin
                  ff_vec_d = vec_q[N_IN-1:0];
                  ff_vld_d = 1'b1;
               end
            end
            if (vec_q == LastVec) begin
               state_d = StDone;
               busy_d  = 1'b0;
               done_d  = 1'b1;
               pass_d  = (err_d == '0);
            end else begin
               state_d    = StDrive;
               vec_d      = vec_q + (N_IN + 1)'(1);
               timer_load = 1'b1;
            end
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   // start is registered first so a sweep begins one edge after the start edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= StIdle;
         start_q  <= 1'b0;
         vec_q    <= '0;
         err_q    <= '0;
         ff_vec_q <= '0;
         ff_vld_q <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         pass_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         start_q  <= start;
         vec_q    <= vec_d;
         err_q    <= err_d;
         ff_vec_q <= ff_vec_d;
         ff_vld_q <= ff_vld_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         pass_q   <= pass_d;
      end
   end

   assign dut_in         = vec_q[N_IN-1:0];
   assign busy           = busy_q;
   assign done           = done_q;
   assign pass           = pass_q;
   assign err_count      = err_q;
   assign first_fail_vec = ff_vec_q;
   assign first_fail_vld = ff_vld_q;

endmodule

// File: tb/tb_gate_vector_checker.sv
// Randomized self-checking bench for gate_vector_checker. Two instances: the default
// 2-input AND checker and a 3-input XOR3 checker with a 3-cycle settle window. Each DUT
// gate is modelled by a bench-owned table so faults can be injected per sweep.
module tb_gate_vector_checker;

   logic       clk;
   logic       rst_n;
   logic       start2, start3;
   logic [1:0] dut_in2;
   logic [2:0] dut_in3;
   logic       dut_out2, dut_out3;
   logic       busy2, busy3, done2, done3, pass2, pass3, vld2, vld3;
   logic [2:0] err2;
   logic [3:0] err3;
   logic [1:0] ff2;
   logic [2:0] ff3;

   logic [3:0] tbl2;
   logic [7:0] tbl3;

   int unsigned n_checks = 0;
   int unsigned n_errors = 0;
   int          sel = 0;

   logic [31:0] cur_dut_in, cur_err, cur_ff;
   logic        cur_busy, cur_done, cur_pass, cur_vld;

   assign dut_out2 = tbl2[dut_in2];
   assign dut_out3 = tbl3[dut_in3];

   gate_vector_checker u_dut2 (
      .clk            (clk),
      .rst_n          (rst_n),
      .start          (start2),
      .dut_in         (dut_in2),
      .dut_out        (dut_out2),
      .busy           (busy2),
      .done           (done2),
      .pass           (pass2),
      .err_count      (err2),
      .first_fail_vec (ff2),
      .first_fail_vld (vld2)
   );

   gate_vector_checker #(
      .N_IN   (3),
      .TRUTH  (8'h96),
      .SETTLE (3)
   ) u_dut3 (
      .clk            (clk),
      .rst_n          (rst_n),
      .start          (start3),
      .dut_in         (dut_in3),
      .dut_out        (dut_out3),
      .busy           (busy3),
      .done           (done3),
      .pass           (pass3),
      .err_count      (err3),
      .first_fail_vec (ff3),
      .first_fail_vld (vld3)
   );

   always_comb begin
      cur_dut_in = (sel != 0) ? 32'(dut_in3) : 32'(dut_in2);
      cur_err    = (sel != 0) ? 32'(err3)    : 32'(err2);
      cur_ff     = (sel != 0) ? 32'(ff3)     : 32'(ff2);
      cur_busy   = (sel != 0) ? busy3 : busy2;
      cur_done   = (sel != 0) ? done3 : done2;
      cur_pass   = (sel != 0) ? pass3 : pass2;
      cur_vld    = (sel != 0) ? vld3  : vld2;
   end

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic set_start(input int s, input logic v);
      if (s != 0) start3 = v;
      else        start2 = v;
   endtask

   task automatic check_reset_state(input string tag);
      check({tag, "_dut_in"}, cur_dut_in, 0);
      check({tag, "_busy"},   32'(cur_busy), 0);
      check({tag, "_done"},   32'(cur_done), 0);
      check({tag, "_pass"},   32'(cur_pass), 0);
      check({tag, "_err"},    cur_err, 0);
      check({tag, "_ffvec"},  cur_ff, 0);
      check({tag, "_ffvld"},  32'(cur_vld), 0);
   endtask

   // One full sweep on instance s; optionally re-pulses start at cycle repulse_at.
   task automatic run_sweep(input string tag, input int s, input int repulse_at);
      int          n, settle, nv, per, exp_lat, exp_err, exp_first, lat, bad;
      logic [7:0]  tbl, truth, diff;
      int          q[$];
      n       = (s != 0) ? 3 : 2;
      settle  = (s != 0) ? 3 : 1;
      nv      = 1 << n;
      per     = settle + 1;
      exp_lat = 1 + nv * per;
      tbl     = (s != 0) ? tbl3 : {4'b0, tbl2};
      truth   = (s != 0) ? 8'h96 : 8'h08;
      diff    = tbl ^ truth;
      exp_err   = 0;
      exp_first = -1;
      for (int v = 0; v < nv; v++) begin
         if (diff[v]) begin
            exp_err++;
            if (exp_first < 0) exp_first = v;
         end
      end

      sel = s;
      @(negedge clk);
      set_start(s, 1'b1);
      @(posedge clk);
      #1;
      set_start(s, 1'b0);
      lat = 0;
      for (int c = 1; c <= 100; c++) begin
         @(posedge clk);
         #1;
         set_start(s, (c == repulse_at));
         if (c == 1) begin
            check({tag, "_clr_err"},  cur_err, 0);
            check({tag, "_clr_vld"},  32'(cur_vld), 0);
            check({tag, "_clr_busy"}, 32'(cur_busy), 1);
         end
         if (cur_done) begin
            lat = c;
            break;
         end
         q.push_back(int'(cur_dut_in));
      end
      set_start(s, 1'b0);

      check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
      check({tag, "_err"},     cur_err, 32'(exp_err));
      check({tag, "_pass"},    32'(cur_pass), 32'(exp_err == 0));
      check({tag, "_ffvld"},   32'(cur_vld), 32'(exp_err != 0));
      if (exp_err != 0) check({tag, "_ffvec"}, cur_ff, 32'(exp_first));
      check({tag, "_busy_end"}, 32'(cur_busy), 0);
      check({tag, "_dut_in_end"}, cur_dut_in, 32'(nv - 1));
      bad = 0;
      for (int i = 0; i < q.size(); i++) begin
         if (q[i] != i / per) bad++;
      end
      check({tag, "_seq_len"}, 32'(q.size()), 32'(nv * per));
      check({tag, "_seq_bad"}, 32'(bad), 0);
   endtask

   initial begin
      rst_n  = 1'b0;
      start2 = 1'b0;
      start3 = 1'b0;
      tbl2   = 4'b1000;
      tbl3   = 8'h96;
      repeat (3) @(posedge clk);
      #1;
      sel = 0;
      #1;
      check_reset_state("rst2");
      sel = 1;
      #1;
      check_reset_state("rst3");
      @(negedge clk);
      rst_n = 1'b1;

      tbl2 = 4'b1000;
      run_sweep("and", 0, 0);
      tbl2 = 4'b0000;
      run_sweep("stuck0", 0, 0);
      tbl2 = 4'b0111;
      run_sweep("nand", 0, 0);
      // Restart from DONE with errors pending, plus an ignored start mid-sweep.
      tbl2 = 4'b1000;
      run_sweep("repulse", 0, 3);

      // Reset in the middle of a sweep, then a clean restart.
      sel  = 0;
      tbl2 = 4'b0111;
      @(negedge clk);
      start2 = 1'b1;
      @(posedge clk);
      #1;
      start2 = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      check_reset_state("midrst");
      @(negedge clk);
      rst_n = 1'b1;
      tbl2  = 4'b1000;
      run_sweep("after_rst", 0, 0);

      tbl3 = 8'h96;
      run_sweep("xor3", 1, 0);

      for (int i = 0; i < 8; i++) begin
         int s;
         s = int'($urandom_range(0, 1));
         if ($urandom_range(0, 3) == 0) begin
            tbl2 = 4'b1000;
            tbl3 = 8'h96;
         end else begin
            tbl2 = 4'($urandom());
            tbl3 = 8'($urandom());
         end
         repeat ($urandom_range(0, 3)) @(posedge clk);
         run_sweep($sformatf("rnd%0d", i), s, (($urandom_range(0, 1) != 0) ? 2 : 0));
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
